// File: rtl/alu_exec_unit_if.sv
// Valid/ready bundle between the ALU control stage and the execute unit.
// Includes the busy stall indication back to fetch/decode.
interface alu_exec_unit_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             illegal;
   logic             busy;

   modport master (
      output in_valid, op, a, b, out_ready,
      input  in_ready, out_valid, result, zero, illegal, busy
   );

   modport slave (
      input  in_valid, op, a, b, out_ready,
      output in_ready, out_valid, result, zero, illegal, busy
   );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith ops, bit-serial shifts.
// Result, zero and illegal are registered and offered via valid/ready.
module alu_exec_unit #(
   parameter int WIDTH = 32
) (
   input logic          clk,
   input logic          reset,
   alu_exec_unit_if.slave io
);
   localparam int SHW = $clog2(WIDTH);

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_XOR = 4'b1100;
   localparam logic [3:0] OP_SLL = 4'b1000;
   localparam logic [3:0] OP_SRL = 4'b1001;
   localparam logic [3:0] OP_SRA = 4'b1010;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic [1:0]       sop_q, sop_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic             illegal_q, illegal_d;

   logic [WIDTH-1:0] alu_res;
   logic             alu_ill;
   logic             is_shift;
   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] acc_sh;

   assign shamt = io.b[SHW-1:0];

   always_comb begin
      alu_res  = '0;
      alu_ill  = 1'b0;
      is_shift = 1'b0;
      case (io.op)
         OP_AND: alu_res = io.a & io.b;
         OP_OR:  alu_res = io.a | io.b;
         OP_ADD: alu_res = io.a + io.b;
         OP_SUB: alu_res = io.a - io.b;
         OP_SLT: alu_res = {{(WIDTH-1){1'b0}},
                            $signed(io.a) < $signed(io.b)};
         OP_XOR: alu_res = io.a ^ io.b;
         OP_SLL,
         OP_SRL,
         OP_SRA: is_shift = 1'b1;
         default: alu_ill = 1'b1;
      endcase
   end

   // sop_q holds op[1:0]: 00 SLL, 01 SRL, 10 SRA
   always_comb begin
      case (sop_q)
         2'b00:   acc_sh = {acc_q[WIDTH-2:0], 1'b0};
         2'b10:   acc_sh = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
         default: acc_sh = {1'b0, acc_q[WIDTH-1:1]};
      endcase
   end

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      sop_d     = sop_q;
      result_d  = result_q;
      zero_d    = zero_q;
      illegal_d = illegal_q;
      case (state_q)
         IDLE: begin
            if (io.in_valid) begin
               if (!is_shift) begin
                  result_d  = alu_res;
                  zero_d    = (alu_res == '0);
                  illegal_d = alu_ill;
                  state_d   = DONE;
               end else if (shamt == '0) begin
                  result_d  = io.a;
                  zero_d    = (io.a == '0);
                  illegal_d = 1'b0;
                  state_d   = DONE;
               end else begin
                  acc_d   = io.a;
                  cnt_d   = shamt;
                  sop_d   = io.op[1:0];
                  state_d = SHIFT;
               end
            end
         end
         SHIFT: begin
            acc_d = acc_sh;
            cnt_d = cnt_q - SHW'(1);
            if (cnt_q == SHW'(1)) begin
               result_d  = acc_sh;
               zero_d    = (acc_sh == '0);
               illegal_d = 1'b0;
               state_d   = DONE;
            end
         end
         DONE: begin
            if (io.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         cnt_q     <= '0;
         sop_q     <= '0;
         result_q  <= '0;
         zero_q    <= 1'b1;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         sop_q     <= sop_d;
         result_q  <= result_d;
         zero_q    <= zero_d;
         illegal_q <= illegal_d;
      end
   end

   assign io.in_ready  = (state_q == IDLE);
   assign io.out_valid = (state_q == DONE);
   assign io.busy      = (state_q != IDLE);
   assign io.result    = result_q;
   assign io.zero      = zero_q;
   assign io.illegal   = illegal_q;
endmodule
